// File: rtl/load_sched_pkg.sv
// Shared types and helpers for the load-value scheduler.
`default_nettype none

package load_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_t;

  // Terminal count of a free-running counter of the given width.
  function automatic logic [63:0] max_count(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_sched_fifo.sv
// Request FIFO for the load-value scheduler; LOAD_SCHED_COALESCE_EN enables
// overwriting the newest entry when a push arrives while full.
`default_nettype none

module load_sched_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    w_idx;
  logic             do_write;
  logic             do_over;
  logic             do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_write = push && !full;
  assign do_pop   = pop && !empty;

`ifdef LOAD_SCHED_COALESCE_EN
  // Newest entry is replaced; when it is also the outstanding head, drop.
  assign do_over = push && full && (level > LW'(1));
`else
  assign do_over = 1'b0;
`endif

  always_comb begin
    w_idx = wr_ptr;
    if (do_over) begin
      w_idx = wr_ptr - PW'(1);
    end
  end

  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_write || do_over) begin
        mem[w_idx] <= wdata;
      end
      if (do_write) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_write, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/load_value_scheduler.sv
// Feeds buffered reload values to the load-value counter, popping each at wrap.
// Optional LOAD_SCHED_COALESCE_EN: always ready, newest entry overwritten when full.
`default_nettype none

module load_value_scheduler
  import load_sched_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst_l,
  input  logic             Req_Valid,
  output logic             Req_Ready,
  input  logic [WIDTH-1:0] Req_Value,
  input  logic [WIDTH-1:0] Count,
  output logic             Load_Value_Valid,
  output logic [WIDTH-1:0] Load_Value,
  output logic             Load_Done,
  output logic [LW-1:0]    Fifo_Level
);

  localparam logic [WIDTH-1:0] MAXC = WIDTH'(max_count(WIDTH));

  sched_state_t state;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push;
  logic         pop;

`ifdef LOAD_SCHED_COALESCE_EN
  assign Req_Ready = 1'b1;
`else
  assign Req_Ready = !fifo_full;
`endif

  assign push = Req_Valid && Req_Ready;
  // The counter only takes the value once its load flag was set by a prior pulse.
  assign pop  = (state == WAIT) && (Count == MAXC) && !fifo_empty;

  load_sched_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (Rst_l),
    .push  (push),
    .pop   (pop),
    .wdata (Req_Value),
    .head  (Load_Value),
    .level (Fifo_Level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge Clk or negedge Rst_l) begin
    if (!Rst_l) begin
      state            <= IDLE;
      Load_Value_Valid <= 1'b0;
      Load_Done        <= 1'b0;
    end else begin
      Load_Value_Valid <= 1'b0;
      Load_Done        <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state            <= ISSUE;
            Load_Value_Valid <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (pop) begin
            Load_Done <= 1'b1;
            if (Fifo_Level > LW'(1)) begin
              state            <= ISSUE;
              Load_Value_Valid <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_value_scheduler.sv
// Bench for load_value_scheduler driving a real load-value counter model.
`default_nettype none

module tb_load_value_scheduler;

  localparam int DEPTH = 4;
  localparam logic [3:0] MAXC = 4'hF;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_value = 4'h0;
  logic [3:0] count;
  logic       lvv;
  logic [3:0] load_value;
  logic       done;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_value_scheduler #(
    .WIDTH (4),
    .DEPTH (DEPTH)
  ) dut (
    .Clk              (clk),
    .Rst_l            (rst_l),
    .Req_Valid        (req_valid),
    .Req_Ready        (req_ready),
    .Req_Value        (req_value),
    .Count            (count),
    .Load_Value_Valid (lvv),
    .Load_Value       (load_value),
    .Load_Done        (done),
    .Fifo_Level       (level)
  );

  // Load-value counter: a pulse arms it, it loads on the next wrap after arming.
  logic ctr_flag;
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      count    <= 4'h0;
      ctr_flag <= 1'b0;
    end else if (ctr_flag && count == MAXC) begin
      count    <= load_value;
      ctr_flag <= 1'b0;
    end else begin
      count <= count + 4'd1;
      if (lvv) ctr_flag <= 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  // Reference model: queue of pending values plus issue/arming bookkeeping.
  logic [3:0] mq[$];
  bit m_pulse = 0, m_done = 0, m_busy = 0, m_armed = 0;
  bit m_take, m_np, m_nd;
  int mn;

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mq.delete();
      m_pulse = 0; m_done = 0; m_busy = 0; m_armed = 0;
    end else begin
      mn     = mq.size();
      m_take = m_armed && (count == MAXC);
      m_np   = 0;
      m_nd   = 0;
`ifdef LOAD_SCHED_COALESCE_EN
      if (req_valid) begin
        if (mn < DEPTH) mq.push_back(req_value);
        else if (mn > 1) mq[mn-1] = req_value;
      end
`else
      if (req_valid && mn < DEPTH) mq.push_back(req_value);
`endif
      if (m_pulse) m_armed = 1;
      if (m_take) begin
        void'(mq.pop_front());
        m_nd    = 1;
        m_armed = 0;
        if (mn > 1) m_np = 1;
        else m_busy = 0;
      end else if (!m_busy && mn != 0) begin
        m_np   = 1;
        m_busy = 1;
      end
      m_pulse = m_np;
      m_done  = m_nd;
    end
  end

  always @(negedge clk) begin
    if (rst_l) begin
`ifdef LOAD_SCHED_COALESCE_EN
      chk("m_ready", req_ready, 1);
`else
      chk("m_ready", req_ready, (mq.size() != DEPTH) ? 1 : 0);
`endif
      chk("m_level", level, mq.size());
      chk("m_load_value", load_value, (mq.size() != 0) ? mq[0] : 0);
      chk("m_valid", lvv, m_pulse);
      chk("m_done", done, m_done);
    end
  end

  task automatic wait_count(input logic [3:0] v);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (count == v) found = 1;
    end
    if (!found) timeout("wait_count");
  endtask

  task automatic wait_done(input logic [3:0] v);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1;
    end
    if (!found) timeout("wait_done");
    else chk("done_count", count, v);
  endtask

  initial begin
    int n;
    bit held;

    // Reset state
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    chk("rst_level", level, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", lvv, 0);
    chk("rst_done", done, 0);
    chk("rst_lv", load_value, 0);

    // Reset mid-WAIT with three entries
    req_valid = 1'b1;
    req_value = 4'h1; @(negedge clk);
    req_value = 4'h2; @(negedge clk);
    req_value = 4'h3; @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_level", level, 3);
    chk("pre_rst_lv", load_value, 1);
    rst_l = 1'b0;
    @(negedge clk);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_valid", lvv, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_lv", load_value, 0);
    rst_l = 1'b1;

    // Single push of 0x5 while Count=0x2
    wait_count(4'h2);
    req_valid = 1'b1; req_value = 4'h5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("t2_pulse", lvv, 1);
    chk("t2_pulse_count", count, 4);
    held = 1; n = 0;
    while (count != MAXC && n < 40) begin
      @(negedge clk);
      n++;
      if (load_value != 4'h5) held = 0;
    end
    chk("t2_held", held, 1);
    chk("t2_reached_max", count, 15);
    @(negedge clk);
    chk("t2_load_count", count, 5);
    chk("t2_done", done, 1);
    chk("t2_level", level, 0);

    // Three back-to-back requests load in order
    req_valid = 1'b1;
    req_value = 4'h3; @(negedge clk);
    req_value = 4'h9; @(negedge clk);
    req_value = 4'hC; @(negedge clk);
    req_valid = 1'b0;
    wait_done(4'h3);
    wait_done(4'h9);
    wait_done(4'hC);

    // Issue pulse on Count=0xF is missed; load at the following wrap
    wait_count(4'hD);
    req_valid = 1'b1; req_value = 4'hA;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("t4_pulse", lvv, 1);
    chk("t4_pulse_count", count, 15);
    @(negedge clk);
    chk("t4_no_load", count, 0);
    chk("t4_no_done", done, 0);
    n = 1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      n++;
    end
    chk("t4_delay", n, 17);
    chk("t4_loaded", count, 10);

    // Fill to four entries
    wait_count(4'h0);
    req_valid = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      req_value = 4'(v);
      @(negedge clk);
    end
    chk("full_level", level, 4);
`ifdef LOAD_SCHED_COALESCE_EN
    chk("full_ready", req_ready, 1);
    req_value = 4'h7;
    @(negedge clk);
    req_valid = 1'b0;
    chk("coal_level", level, 4);
    wait_done(4'h1);
    wait_done(4'h2);
    wait_done(4'h3);
    wait_done(4'h7);
`else
    chk("full_ready", req_ready, 0);
    req_value = 4'h6;
    @(negedge clk);
    chk("full_hold_level", level, 4);
    chk("full_hold_ready", req_ready, 0);
    wait_done(4'h1);
    chk("after_pop_ready", req_ready, 1);
    chk("after_pop_level", level, 3);
    @(negedge clk);
    req_valid = 1'b0;
    chk("fifth_accepted", level, 4);
    wait_done(4'h2);
    wait_done(4'h3);
    wait_done(4'h4);
    wait_done(4'h6);
`endif
    repeat (3) @(negedge clk);
    chk("end_level", level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
